// File: rtl/t03_game_pkg.sv
// ----------------------------------------------------------------------------
// t03_game_pkg
// Types and constants shared by the game state controller and the alphabet
// decoder.
//   game_state_t   : 3-bit match phase, encoded 0..6 (7 never driven)
//   GLYPH_DIGIT0   : glyph code of digit '0'; digit d maps to GLYPH_DIGIT0 + d
//   GLYPH_BLANK    : glyph code of an empty cell
//   HEALTH_W       : width of a player's binary health counter (0..99)
//   health_sat_sub : health minus damage, clamped at zero
// ----------------------------------------------------------------------------
package t03_game_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReady = 3'd1,
        StSet   = 3'd2,
        StFight = 3'd3,
        StPlay  = 3'd4,
        StWinP1 = 3'd5,
        StWinP2 = 3'd6
    } game_state_t;

    localparam int unsigned HEALTH_W     = 7;
    localparam int unsigned DMG_W        = 4;
    localparam int unsigned GLYPH_W      = 6;
    localparam int unsigned GLYPH_PAIR_W = 2 * GLYPH_W;
    localparam int unsigned HEALTH_MAX   = 99;

    localparam logic [GLYPH_W-1:0] GLYPH_DIGIT0 = 6'd26;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK  = 6'd37;

    // Damage larger than the remaining health leaves the player at zero.
    function automatic logic [HEALTH_W-1:0] health_sat_sub(
        input logic [HEALTH_W-1:0] health,
        input logic [DMG_W-1:0]    dmg
    );
        logic [HEALTH_W-1:0] dmg_ext;
        dmg_ext = HEALTH_W'(dmg);
        if (health > dmg_ext) begin
            return health - dmg_ext;
        end
        return '0;
    endfunction

endpackage

// File: rtl/t03_health_to_glyph.sv
// ----------------------------------------------------------------------------
// t03_health_to_glyph
// Combinational conversion of a binary health value (0..99) into a pair of
// digit glyph codes {tens, ones}. A leading zero is shown as the '0' glyph.
// Ports:
//   health_i [HEALTH_W-1:0]     binary health, 0..99 (larger values shown as 99)
//   glyph_o  [GLYPH_PAIR_W-1:0] {tens glyph, ones glyph}
// ----------------------------------------------------------------------------
module t03_health_to_glyph
    import t03_game_pkg::*;
(
    input  logic [HEALTH_W-1:0]     health_i,
    output logic [GLYPH_PAIR_W-1:0] glyph_o
);

    logic [HEALTH_W-1:0] health_clamped;
    logic [3:0]          tens;
    logic [HEALTH_W-1:0] ones;

    assign health_clamped = (health_i > HEALTH_W'(HEALTH_MAX)) ? HEALTH_W'(HEALTH_MAX)
                                                               : health_i;

    // Divide by ten with a compare ladder: the highest multiple of ten not
    // above the value gives the tens digit, the remainder is the ones digit.
    always_comb begin
        tens = '0;
        ones = health_clamped;
        for (int unsigned i = 1; i < 10; i++) begin
            if (health_clamped >= HEALTH_W'(10 * i)) begin
                tens = 4'(i);
                ones = health_clamped - HEALTH_W'(10 * i);
            end
        end
    end

    assign glyph_o = {GLYPH_DIGIT0 + GLYPH_W'(tens), GLYPH_DIGIT0 + GLYPH_W'(ones)};

endmodule

// File: rtl/t03_game_state_controller.sv
// ----------------------------------------------------------------------------
// t03_game_state_controller
// Sequences a match: IDLE -> READY -> SET -> FIGHT -> PLAY -> WIN_Px -> IDLE.
// The three banner phases each last PHASE_TICKS clocks, the winner banner
// WIN_HOLD_TICKS clocks. Both players' health lives here as 0..99 counters
// and is only reduced by hits during PLAY.
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   start_i        start button level; a rising edge starts a match from IDLE
//   p1_hit_i       one-cycle pulse, P1 took p1_dmg_i damage
//   p1_dmg_i [3:0] damage for p1_hit_i
//   p2_hit_i       one-cycle pulse, P2 took p2_dmg_i damage
//   p2_dmg_i [3:0] damage for p2_hit_i
//   game_state_o   registered match phase (game_state_t encoding)
//   p1health_o     {tens glyph, ones glyph} of P1 health
//   p2health_o     {tens glyph, ones glyph} of P2 health
//   fight_active_o registered, high exactly while game_state_o == PLAY
// ----------------------------------------------------------------------------
module t03_game_state_controller
    import t03_game_pkg::*;
#(
    parameter int unsigned PHASE_TICKS    = 10_000_000,
    parameter int unsigned WIN_HOLD_TICKS = 30_000_000,
    parameter int unsigned START_HEALTH   = 99
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    p1_hit_i,
    input  logic [DMG_W-1:0]        p1_dmg_i,
    input  logic                    p2_hit_i,
    input  logic [DMG_W-1:0]        p2_dmg_i,
    output logic [2:0]              game_state_o,
    output logic [GLYPH_PAIR_W-1:0] p1health_o,
    output logic [GLYPH_PAIR_W-1:0] p2health_o,
    output logic                    fight_active_o
);

    localparam int unsigned MaxTicks = (PHASE_TICKS > WIN_HOLD_TICKS) ? PHASE_TICKS
                                                                      : WIN_HOLD_TICKS;
    localparam int unsigned TimerW   = $clog2(MaxTicks);

    localparam logic [TimerW-1:0]   PhaseLast  = TimerW'(PHASE_TICKS - 1);
    localparam logic [TimerW-1:0]   WinLast    = TimerW'(WIN_HOLD_TICKS - 1);
    localparam logic [HEALTH_W-1:0] HealthInit = HEALTH_W'(START_HEALTH);

    game_state_t         state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [HEALTH_W-1:0] p1_health_q, p1_health_d;
    logic [HEALTH_W-1:0] p2_health_q, p2_health_d;
    logic                start_prev_q;
    logic                fight_active_q;
    logic                start_rise;

    assign start_rise = start_i & ~start_prev_q;

    // start_prev resets high so a button held through reset cannot start a
    // match until it has been released once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            p1_health_q    <= HealthInit;
            p2_health_q    <= HealthInit;
            start_prev_q   <= 1'b1;
            fight_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            p1_health_q    <= p1_health_d;
            p2_health_q    <= p2_health_d;
            start_prev_q   <= start_i;
            fight_active_q <= (state_d == StPlay);
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;

        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (start_rise) begin
                    state_d     = StReady;
                    p1_health_d = HealthInit;
                    p2_health_d = HealthInit;
                end
            end

            StReady, StSet, StFight: begin
                if (timer_q == PhaseLast) begin
                    timer_d = '0;
                    case (state_q)
                        StReady: state_d = StSet;
                        StSet:   state_d = StFight;
                        default: state_d = StPlay;
                    endcase
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end

            StPlay: begin
                timer_d = '0;
                if (p1_hit_i) begin
                    p1_health_d = health_sat_sub(p1_health_q, p1_dmg_i);
                end
                if (p2_hit_i) begin
                    p2_health_d = health_sat_sub(p2_health_q, p2_dmg_i);
                end
                // Decide on post-hit health so the lethal hit and the win
                // banner land on the same edge; P1 wins a double knockout.
                if (p2_health_d == '0) begin
                    state_d = StWinP1;
                end else if (p1_health_d == '0) begin
                    state_d = StWinP2;
                end
            end

            StWinP1, StWinP2: begin
                if (timer_q == WinLast) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    assign game_state_o   = state_q;
    assign fight_active_o = fight_active_q;

    t03_health_to_glyph u_p1_glyph (
        .health_i (p1_health_q),
        .glyph_o  (p1health_o)
    );

    t03_health_to_glyph u_p2_glyph (
        .health_i (p2_health_q),
        .glyph_o  (p2health_o)
    );

endmodule

// File: tb/tb_t03_game_state_controller.sv
// ----------------------------------------------------------------------------
// tb_t03_game_state_controller
// Directed match scenarios against a behavioural model that tracks the match
// phase, cycles spent in it and each player's health as plain integers.
// ----------------------------------------------------------------------------
module tb_t03_game_state_controller;

    localparam int PT = 4;
    localparam int WH = 6;
    localparam int SH = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b1;
    logic        p1_hit = 1'b0;
    logic [3:0]  p1_dmg = '0;
    logic        p2_hit = 1'b0;
    logic [3:0]  p2_dmg = '0;
    logic [2:0]  game_state;
    logic [11:0] p1health;
    logic [11:0] p2health;
    logic        fight_active;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    t03_game_state_controller #(
        .PHASE_TICKS    (PT),
        .WIN_HOLD_TICKS (WH),
        .START_HEALTH   (SH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .p1_hit_i       (p1_hit),
        .p1_dmg_i       (p1_dmg),
        .p2_hit_i       (p2_hit),
        .p2_dmg_i       (p2_dmg),
        .game_state_o   (game_state),
        .p1health_o     (p1health),
        .p2health_o     (p2health),
        .fight_active_o (fight_active)
    );

    // Model: phase number, cycles already spent in it, both healths.
    typedef struct {
        int st;
        int el;
        int h1;
        int h2;
        bit prev;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.st = 0; r.el = 0; r.h1 = SH; r.h2 = SH; r.prev = 1'b1;
        return r;
    endfunction

    function automatic model_t step(model_t c, logic s, logic h1, logic [3:0] d1,
                                    logic h2, logic [3:0] d2);
        model_t n = c;
        n.prev = s;
        case (c.st)
            0: if (s && !c.prev) begin
                n.st = 1; n.el = 0; n.h1 = SH; n.h2 = SH;
            end
            1, 2, 3: begin
                n.el = c.el + 1;
                if (n.el == PT) begin
                    n.st = c.st + 1; n.el = 0;
                end
            end
            4: begin
                if (h1) n.h1 = (c.h1 > int'(d1)) ? c.h1 - int'(d1) : 0;
                if (h2) n.h2 = (c.h2 > int'(d2)) ? c.h2 - int'(d2) : 0;
                if (n.h2 == 0) n.st = 5;
                else if (n.h1 == 0) n.st = 6;
            end
            default: begin
                n.el = c.el + 1;
                if (n.el == WH) begin
                    n.st = 0; n.el = 0;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= step(m, start, p1_hit, p1_dmg, p2_hit, p2_dmg);
    end

    function automatic logic [11:0] glyph(int h);
        return {6'(26 + h / 10), 6'(26 + h % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model.game_state", 32'(game_state), 32'(m.st));
        chk("model.fight_active", 32'(fight_active), 32'(m.st == 4));
        chk("model.p1health", 32'(p1health), 32'(glyph(m.h1)));
        chk("model.p2health", 32'(p2health), 32'(glyph(m.h2)));
    endtask

    // One clock; outputs are sampled at the falling edge, away from the
    // active edge, and checked against the model every cycle.
    task automatic tick();
        @(negedge clk);
        compare_model();
    endtask

    task automatic hit(input logic h1, input logic [3:0] d1, input logic h2,
                       input logic [3:0] d2);
        p1_hit = h1; p1_dmg = d1; p2_hit = h2; p2_dmg = d2;
        tick();
        p1_hit = 1'b0; p1_dmg = '0; p2_hit = 1'b0; p2_dmg = '0;
    endtask

    task automatic start_match();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_rise_to_ready", 32'(game_state), 32'd1);
    endtask

    // Walks READY/SET/FIGHT checking each lasts PT clocks; hits and a start
    // pulse are injected along the way and must be ignored.
    task automatic to_play();
        for (int ph = 1; ph <= 3; ph++) begin
            for (int i = 0; i < PT; i++) begin
                chk("banner_phase", 32'(game_state), 32'(ph));
                if (ph == 1 && i == 1) begin
                    hit(1'b1, 4'd5, 1'b1, 4'd9);
                end else if (ph == 2 && i == 1) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end else if (ph == 3 && i == 2) begin
                    hit(1'b1, 4'd15, 1'b1, 4'd15);
                end else begin
                    tick();
                end
            end
        end
        chk("play_state", 32'(game_state), 32'd4);
        chk("play_fight_active", 32'(fight_active), 32'd1);
        chk("play_p1health_20", 32'(p1health), 32'({6'd28, 6'd26}));
        chk("play_p2health_20", 32'(p2health), 32'({6'd28, 6'd26}));
    endtask

    task automatic hold_win(input int winner);
        for (int i = 0; i < WH; i++) begin
            chk("win_hold", 32'(game_state), 32'(winner));
            if (i == 1) hit(1'b1, 4'd3, 1'b1, 4'd3);
            else        tick();
        end
        chk("win_to_idle", 32'(game_state), 32'd0);
    endtask

    initial begin
        // Reset with the start button held down.
        tick();
        tick();
        chk("reset_state", 32'(game_state), 32'd0);
        chk("reset_fight_active", 32'(fight_active), 32'd0);
        chk("reset_p1health", 32'(p1health), 32'({6'd28, 6'd26}));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("held_start_no_match", 32'(game_state), 32'd0);

        // Match 1: P2 knocked out in two hits, a zero-damage hit in between.
        start_match();
        to_play();
        hit(1'b0, 4'd0, 1'b1, 4'd7);
        chk("p2health_13", 32'(p2health), 32'({6'd27, 6'd29}));
        hit(1'b0, 4'd0, 1'b1, 4'd0);
        chk("p2health_dmg0", 32'(p2health), 32'({6'd27, 6'd29}));
        hit(1'b0, 4'd0, 1'b1, 4'd15);
        chk("p2health_00", 32'(p2health), 32'({6'd26, 6'd26}));
        chk("lethal_same_edge", 32'(game_state), 32'd5);
        chk("win_fight_inactive", 32'(fight_active), 32'd0);
        hold_win(5);
        chk("win_health_frozen", 32'(p1health), 32'({6'd28, 6'd26}));

        // Match 2: simultaneous hits, double knockout goes to P1.
        start_match();
        to_play();
        hit(1'b1, 4'd15, 1'b1, 4'd15);
        chk("both_05_p1", 32'(p1health), 32'({6'd26, 6'd31}));
        chk("both_05_p2", 32'(p2health), 32'({6'd26, 6'd31}));
        hit(1'b1, 4'd15, 1'b1, 4'd15);
        chk("both_00_p1", 32'(p1health), 32'({6'd26, 6'd26}));
        chk("both_00_p2", 32'(p2health), 32'({6'd26, 6'd26}));
        chk("double_ko_p1_wins", 32'(game_state), 32'd5);
        hold_win(5);

        // Match 3: reset mid-PLAY with health 5 / 9.
        start_match();
        to_play();
        hit(1'b1, 4'd15, 1'b1, 4'd11);
        chk("p1health_05", 32'(p1health), 32'({6'd26, 6'd31}));
        chk("p2health_09", 32'(p2health), 32'({6'd26, 6'd35}));
        #2 rst_n = 1'b0;
        #1;
        chk("midplay_reset_state", 32'(game_state), 32'd0);
        chk("midplay_reset_fight", 32'(fight_active), 32'd0);
        chk("midplay_reset_p1", 32'(p1health), 32'({6'd28, 6'd26}));
        chk("midplay_reset_p2", 32'(p2health), 32'({6'd28, 6'd26}));
        compare_model();
        tick();
        rst_n = 1'b1;
        tick();

        // Match 4: P1 knocked out, P2 wins.
        start_match();
        to_play();
        hit(1'b1, 4'd15, 1'b1, 4'd0);
        hit(1'b1, 4'd15, 1'b0, 4'd0);
        chk("p1_ko_p2_wins", 32'(game_state), 32'd6);
        chk("p1_ko_health", 32'(p1health), 32'({6'd26, 6'd26}));
        hold_win(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
